// File: rtl/alu_pipe32.sv
// 32-bit execute-stage ALU: add/sub/and/or/sll/sra with ne/lt/overflow flags.
// All outputs are registered once; a new operation is accepted every cycle.
module alu_pipe32 (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    logic [31:0] a, b;
    logic        is_sub;
    logic [31:0] b_op;
    logic [31:0] sum;
    logic        sum_ovf;

    assign a = data_operandA;
    assign b = data_operandB;

    // Shared adder: SUB is A + ~B + 1, carry-out dropped.
    assign is_sub  = (ctrl_ALUopcode == OP_SUB);
    assign b_op    = is_sub ? ~b : b;
    assign sum     = a + b_op + 32'(is_sub);
    assign sum_ovf = (a[31] == b_op[31]) && (sum[31] != a[31]);

    // Dedicated subtractor so the flags do not depend on the opcode.
    logic [31:0] cmp_diff;
    logic        cmp_ovf;

    assign cmp_diff = a + ~b + 32'd1;
    assign cmp_ovf  = (a[31] != b[31]) && (cmp_diff[31] != a[31]);

    logic [4:0]  sh;
    logic [31:0] l1, l2, l4, l8, l16;
    logic [31:0] r1, r2, r4, r8, r16;
    logic        sgn;

    assign sh  = ctrl_shiftamt;
    assign sgn = a[31];

    assign l1  = sh[0] ? {a[30:0],   1'b0}  : a;
    assign l2  = sh[1] ? {l1[29:0],  2'b0}  : l1;
    assign l4  = sh[2] ? {l2[27:0],  4'b0}  : l2;
    assign l8  = sh[3] ? {l4[23:0],  8'b0}  : l4;
    assign l16 = sh[4] ? {l8[15:0], 16'b0}  : l8;

    assign r1  = sh[0] ? {sgn,        a[31:1]}   : a;
    assign r2  = sh[1] ? {{2{sgn}},  r1[31:2]}  : r1;
    assign r4  = sh[2] ? {{4{sgn}},  r2[31:4]}  : r2;
    assign r8  = sh[3] ? {{8{sgn}},  r4[31:8]}  : r4;
    assign r16 = sh[4] ? {{16{sgn}}, r8[31:16]} : r8;

    logic [31:0] res_d;
    logic        ovf_d;

    always_comb begin
        res_d = 32'd0;
        ovf_d = 1'b0;
        unique case (ctrl_ALUopcode)
            OP_ADD,
            OP_SUB: begin
                res_d = sum;
                ovf_d = sum_ovf;
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_SLL:  res_d = l16;
            OP_SRA:  res_d = r16;
            default: res_d = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_result <= 32'd0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            data_result <= res_d;
            isNotEqual  <= |cmp_diff;
            isLessThan  <= cmp_diff[31] ^ cmp_ovf;
            overflow    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe32.sv
// Bench for alu_pipe32: directed corner cases then random operations
// compared against an arithmetic reference model.
module tb_alu_pipe32;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    alu_pipe32 dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed math on wide integers, shifts via language operators.
    task automatic model(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         output logic [31:0] r, output logic ne,
                         output logic lt, output logic ov);
        longint sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ne = (a != b);
        lt = (sa < sb);
        ov = 1'b0;
        r  = 32'd0;
        case (op)
            5'd0: begin
                wide = sa + sb;
                r  = a + b;
                ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            5'd1: begin
                wide = sa - sb;
                r  = a - b;
                ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << sh;
            5'd5: r = $unsigned($signed(a) >>> sh);
            default: r = 32'd0;
        endcase
    endtask

    task automatic step(input logic rst, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input string tag);
        logic [31:0] er;
        logic        ene, elt, eov;
        reset          = rst;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_ALUopcode = op;
        ctrl_shiftamt  = sh;
        @(posedge clock);
        #1;
        if (rst) begin
            er = 0; ene = 0; elt = 0; eov = 0;
        end else begin
            model(op, a, b, sh, er, ene, elt, eov);
        end
        check({tag, ".res"}, data_result, er);
        check({tag, ".ne"}, 32'(isNotEqual), 32'(ene));
        check({tag, ".lt"}, 32'(isLessThan), 32'(elt));
        check({tag, ".ovf"}, 32'(overflow), 32'(eov));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, "rst0");
        step(1'b1, 5'd1, 32'h8000_0001, 32'd7, 5'd3, "rst1");
        check("rst.direct", data_result, 32'd0);
        step(1'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, "rel");
        check("rel.direct", {data_result[31:1], overflow}, 32'd0);

        for (int i = 0; i <= 30; i++) begin
            step(1'b0, 5'd0, 32'd1 << i, 32'd1 << i, 5'd9, "add_sweep");
            check("add_sweep.direct", data_result, 32'd1 << (i + 1));
        end
        step(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, "add_zero");

        step(1'b0, 5'd0, 32'h8000_0000, 32'h8000_0000, 5'd0, "add_min");
        check("add_min.ovf1", 32'(overflow), 32'd1);
        step(1'b0, 5'd0, 32'h4000_0000, 32'h4000_0000, 5'd0, "add_pos");
        check("add_pos.res1", data_result, 32'h8000_0000);
        step(1'b0, 5'd1, 32'h8000_0000, 32'h8000_0000, 5'd0, "sub_min");
        check("sub_min.ovf0", 32'(overflow), 32'd0);
        step(1'b0, 5'd1, 32'h8000_0000, 32'h0F00_0000, 5'd0, "sub_ovf");
        check("sub_ovf.ovf1", 32'(overflow), 32'd1);
        step(1'b0, 5'd1, 32'd0, 32'd0, 5'd0, "sub_zero");

        step(1'b0, 5'd1, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 5'd0, "cmp_ne");
        step(1'b0, 5'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd0, "cmp_lt");
        check("cmp_lt.direct", 32'(isLessThan), 32'd1);

        step(1'b0, 5'd3, 32'd0, 32'd0, 5'd0, "or0");
        step(1'b0, 5'd3, 32'hFFFF_FFFF, 32'd0, 5'd0, "or1");
        step(1'b0, 5'd3, 32'd0, 32'hFFFF_FFFF, 5'd0, "or2");
        step(1'b0, 5'd2, 32'hFFFF_FFFF, 32'd0, 5'd0, "and0");
        step(1'b0, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "and1");

        for (int s = 0; s < 32; s++)
            step(1'b0, 5'd4, 32'd1, 32'hDEAD_BEEF, 5'(s), "sll");
        step(1'b0, 5'd5, 32'd0, 32'd0, 5'd0, "sra0");
        step(1'b0, 5'd5, 32'h8000_0000, 32'd0, 5'd4, "sra4");
        check("sra4.direct", data_result, 32'hF800_0000);
        step(1'b0, 5'd5, 32'h8000_0000, 32'd0, 5'd31, "sra31");
        step(1'b0, 5'd7, 32'h1234_5678, 32'h1111_1111, 5'd3, "op7");

        for (int n = 0; n < 300; n++)
            step(1'b0, 5'($urandom_range(0, 9)), pick(), pick(),
                 5'($urandom), "rand");

        step(1'b1, 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, "rst_late");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
